// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-port LSU arbiter: FSM state, port ids and the request bundle.
package lsu_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [2:0]            func3;
    } req_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lsu_arb_starve_ctr.sv
// Saturating wait counter for the debug port; o_force rises once it has waited MAX_WAIT cycles.
module lsu_arb_starve_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vld,
    input  logic i_grant,
    output logic o_force
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_vld || i_grant) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(MAX_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_force = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/lsu_port_arbiter.sv
// Two-requester arbiter in front of the LSU data port: fixed priority for the core with a
// starvation-forced grant for the debug port. Optional counters under LSU_ARB_PERF_EN.
module lsu_port_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req_vld,
    input  logic [1:0]            i_req_we,
    input  logic [2*ADDR_W-1:0]   i_req_addr,
    input  logic [2*DATA_W-1:0]   i_req_wdata,
    input  logic [5:0]            i_req_func3,
    output logic [1:0]            o_req_rdy,
    output logic [1:0]            o_rsp_vld,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic [ADDR_W-1:0]     o_lsu_addr,
    output logic [DATA_W-1:0]     o_lsu_wdata,
    output logic                  o_lsu_wren,
    output logic [2:0]            o_lsu_func3,
    input  logic [DATA_W-1:0]     i_lsu_rdata,
`ifdef LSU_ARB_PERF_EN
    output logic [31:0]           o_perf_grant0,
    output logic [31:0]           o_perf_grant1,
    output logic [31:0]           o_perf_forced,
`endif
    output logic                  o_busy
);

    localparam int LW = (RD_LAT <= 2) ? 1 : $clog2(RD_LAT);

    arb_state_e        state_q, state_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] own_addr_q, own_addr_d;
    logic [2:0]        own_func3_q, own_func3_d;
    logic [1:0]        rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    req_t req_s [2];
    req_t win_req;
    logic win;
    logic starve_force;
    logic accept_ok;
    logic accept;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_s[gi] = '{
                we:    i_req_we[gi],
                addr:  REQ_ADDR_W'(i_req_addr[gi*ADDR_W +: ADDR_W]),
                wdata: REQ_DATA_W'(i_req_wdata[gi*DATA_W +: DATA_W]),
                func3: i_req_func3[gi*3 +: 3]
            };
            assign o_req_rdy[gi] = accept_ok && (win == 1'(gi));
        end
    endgenerate

    lsu_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vld   (i_req_vld[PORT_DBG]),
        .i_grant (accept && (win == PORT_DBG)),
        .o_force (starve_force)
    );

    // Gating with i_rst keeps every output low while reset is held, including ready.
    assign accept_ok = (state_q == ARB_IDLE) && !i_rst;
    assign win       = (starve_force && i_req_vld[PORT_DBG]) ? PORT_DBG :
                       (i_req_vld[PORT_CORE] ? PORT_CORE : PORT_DBG);
    assign win_req   = req_s[win];
    assign accept    = accept_ok && i_req_vld[win];

    always_comb begin
        o_lsu_addr  = '0;
        o_lsu_wdata = '0;
        o_lsu_wren  = 1'b0;
        o_lsu_func3 = '0;
        if (accept) begin
            o_lsu_addr  = win_req.addr[ADDR_W-1:0];
            o_lsu_wdata = win_req.wdata[DATA_W-1:0];
            o_lsu_wren  = win_req.we;
            o_lsu_func3 = win_req.func3;
        end else if (state_q == ARB_WAIT) begin
            o_lsu_addr  = own_addr_q;
            o_lsu_func3 = own_func3_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        owner_d     = owner_q;
        own_addr_d  = own_addr_q;
        own_func3_d = own_func3_q;
        rsp_vld_d   = '0;
        rsp_rdata_d = '0;
        if (state_q == ARB_IDLE) begin
            if (accept) begin
                if (win_req.we) begin
                    rsp_vld_d = port_onehot(win);
                end else begin
                    state_d     = ARB_WAIT;
                    lat_d       = LW'(RD_LAT - 1);
                    owner_d     = win;
                    own_addr_d  = win_req.addr[ADDR_W-1:0];
                    own_func3_d = win_req.func3;
                end
            end
        end else begin
            // Load data is valid in the last WAIT cycle; the response is the registered copy.
            if (lat_q == '0) begin
                rsp_vld_d   = port_onehot(owner_q);
                rsp_rdata_d = i_lsu_rdata;
                state_d     = ARB_IDLE;
            end else begin
                lat_d = lat_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ARB_IDLE;
            lat_q       <= '0;
            owner_q     <= 1'b0;
            own_addr_q  <= '0;
            own_func3_q <= '0;
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            owner_q     <= owner_d;
            own_addr_q  <= own_addr_d;
            own_func3_q <= own_func3_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign o_rsp_vld   = rsp_vld_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_busy      = (state_q == ARB_WAIT);

`ifdef LSU_ARB_PERF_EN
    logic [31:0] perf_g0_q, perf_g0_d;
    logic [31:0] perf_g1_q, perf_g1_d;
    logic [31:0] perf_forced_q, perf_forced_d;

    always_comb begin
        perf_g0_d     = perf_g0_q;
        perf_g1_d     = perf_g1_q;
        perf_forced_d = perf_forced_q;
        if (accept && (win == PORT_CORE)) begin
            perf_g0_d = perf_g0_q + 32'd1;
        end
        if (accept && (win == PORT_DBG)) begin
            perf_g1_d = perf_g1_q + 32'd1;
            if (starve_force) begin
                perf_forced_d = perf_forced_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_g0_q     <= '0;
            perf_g1_q     <= '0;
            perf_forced_q <= '0;
        end else begin
            perf_g0_q     <= perf_g0_d;
            perf_g1_q     <= perf_g1_d;
            perf_forced_q <= perf_forced_d;
        end
    end

    assign o_perf_grant0 = perf_g0_q;
    assign o_perf_grant1 = perf_g1_q;
    assign o_perf_forced = perf_forced_q;
`endif

endmodule
